pet_need_fsm: RTL and testbench

- Parametrised successor of the pet hunger state machine.
- Owns the food-level counter internally: time-based decay on a tick, refill while feeding.
- Derives pet state from programmable thresholds and has a clean, clock-synchronous test mode that steps states on a debounced test pulse.
- Sits between input conditioning (buttons, sensors, tick divider) and the display/LED driver.

---
 rtl/pet_pkg.sv | 21 ++
 rtl/pet_need_fsm_sync_edge_det.sv | 27 ++
 rtl/pet_need_fsm.sv | 178 +++++++++++++++++
 tb/tb_pet_need_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pet_pkg.sv
// Shared encodings for the pet need state machine family.
package pet_pkg;

   localparam int STATE_W    = 3;
   localparam int TEST_STEPS = 4;
   localparam int TEST_IDX_W = $clog2(TEST_STEPS);

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_HUNGRY   = 3'd1,
      ST_STARVING = 3'd2,
      ST_EATING   = 3'd3,
      ST_SLEEP    = 3'd4
   } state_t;

   // Test mode walks the first TEST_STEPS encodings directly.
   function automatic state_t test_state(input logic [TEST_IDX_W-1:0] idx);
      return state_t'(STATE_W'(idx));
   endfunction

endpackage

// File: rtl/pet_need_fsm_sync_edge_det.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse output.
module sync_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/pet_need_fsm.sv
// Pet need state machine: owns the food level, derives state from thresholds,
// and offers a stepped test mode. Optional SLEEP state via PET_NEED_SLEEP_EN.
module pet_need_fsm
   import pet_pkg::*;
#(
   parameter int LEVEL_W     = 2,
   parameter int LEVEL_MAX   = 3,
   parameter int HUNGRY_TH   = 3,
   parameter int STARVE_TH   = 1,
   parameter int DECAY_TICKS = 4,
   parameter int FEED_TICKS  = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  btn_feed,
   input  logic                  test_mode,
   input  logic                  test_step_raw,
   input  logic                  light_dark,
   output logic [STATE_W-1:0]    state,
   output logic [LEVEL_W-1:0]    food_level,
   output logic                  feed_enable,
   output logic [TEST_IDX_W-1:0] test_idx,
   output logic                  state_chg
);

   localparam int DCW = $clog2(DECAY_TICKS + 1);
   localparam int FCW = $clog2(FEED_TICKS + 1);
   localparam logic [DCW-1:0]     DECAY_LAST = DCW'(DECAY_TICKS);
   localparam logic [FCW-1:0]     FEED_LAST  = FCW'(FEED_TICKS);
   localparam logic [LEVEL_W-1:0] LVL_FULL   = LEVEL_W'(LEVEL_MAX);
   localparam logic [LEVEL_W:0]   HUNGRY_LIM = (LEVEL_W+1)'(HUNGRY_TH);
   localparam logic [LEVEL_W:0]   STARVE_LIM = (LEVEL_W+1)'(STARVE_TH);

   state_t                r_state;
   logic [LEVEL_W-1:0]    r_level;
   logic [DCW-1:0]        r_decay_cnt;
   logic [FCW-1:0]        r_feed_cnt;
   logic [TEST_IDX_W-1:0] r_test_idx;
   logic                  r_feed_en;
   logic                  r_state_chg;

   state_t                w_next_state;
   logic                  w_step;
   logic [TEST_IDX_W-1:0] w_idx_next;
   logic [DCW-1:0]        w_decay_inc;
   logic [FCW-1:0]        w_feed_inc;
   logic                  w_lt_hungry;
   logic                  w_lt_starve;
   logic                  w_full;
   logic                  w_frozen;

   sync_edge_det u_step_det (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (test_step_raw),
      .o_pulse (w_step)
   );

   assign w_idx_next  = w_step ? r_test_idx + 1'b1 : r_test_idx;
   assign w_decay_inc = r_decay_cnt + 1'b1;
   assign w_feed_inc  = r_feed_cnt + 1'b1;
   assign w_lt_hungry = {1'b0, r_level} < HUNGRY_LIM;
   assign w_lt_starve = {1'b0, r_level} < STARVE_LIM;
   assign w_full      = (r_level == LVL_FULL);

`ifdef PET_NEED_SLEEP_EN
   logic r_dark_seen;
   logic w_sleep_go;

   // Second consecutive dark tick requests sleep.
   assign w_sleep_go = tick & light_dark & r_dark_seen;
   assign w_frozen   = test_mode | (r_state == ST_SLEEP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_dark_seen <= 1'b0;
      else if (test_mode)
         r_dark_seen <= 1'b0;
      else if (tick)
         r_dark_seen <= light_dark;
   end
`else
   logic w_unused_light;
   assign w_unused_light = light_dark;
   assign w_frozen       = test_mode;
`endif

   always_comb begin
      w_next_state = r_state;
      if (test_mode) begin
         w_next_state = test_state(w_idx_next);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_lt_hungry)     w_next_state = ST_HUNGRY;
`ifdef PET_NEED_SLEEP_EN
               else if (w_sleep_go) w_next_state = ST_SLEEP;
`endif
            end
            ST_HUNGRY: begin
               if (w_lt_starve)     w_next_state = ST_STARVING;
               else if (btn_feed)   w_next_state = ST_EATING;
`ifdef PET_NEED_SLEEP_EN
               else if (w_sleep_go) w_next_state = ST_SLEEP;
`endif
            end
            ST_STARVING: begin
               if (btn_feed)        w_next_state = ST_EATING;
            end
            ST_EATING: begin
               if (btn_feed && !w_full) w_next_state = ST_EATING;
               else if (w_full)         w_next_state = ST_IDLE;
               else if (!w_lt_starve)   w_next_state = ST_HUNGRY;
               else                     w_next_state = ST_STARVING;
            end
`ifdef PET_NEED_SLEEP_EN
            ST_SLEEP: begin
               if (tick && !light_dark)
                  w_next_state = w_lt_hungry ? ST_HUNGRY : ST_IDLE;
            end
`endif
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_level     <= LVL_FULL;
         r_decay_cnt <= '0;
         r_feed_cnt  <= '0;
         r_test_idx  <= '0;
         r_feed_en   <= 1'b1;
         r_state_chg <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_state_chg <= (w_next_state != r_state);
         r_feed_en   <= !test_mode && (w_next_state == ST_IDLE ||
                                       w_next_state == ST_HUNGRY ||
                                       w_next_state == ST_STARVING);
         r_test_idx  <= test_mode ? w_idx_next : '0;

         // Level moves on the pre-transition state; frozen states hold counters.
         if (!w_frozen) begin
            if (r_state == ST_EATING) begin
               r_decay_cnt <= '0;
               if (tick) begin
                  if (w_feed_inc == FEED_LAST) begin
                     r_feed_cnt <= '0;
                     if (!w_full) r_level <= r_level + 1'b1;
                  end else begin
                     r_feed_cnt <= w_feed_inc;
                  end
               end
            end else begin
               r_feed_cnt <= '0;
               if (tick) begin
                  if (w_decay_inc == DECAY_LAST) begin
                     r_decay_cnt <= '0;
                     if (r_level != '0) r_level <= r_level - 1'b1;
                  end else begin
                     r_decay_cnt <= w_decay_inc;
                  end
               end
            end
         end
      end
   end

   assign state       = r_state;
   assign food_level  = r_level;
   assign feed_enable = r_feed_en;
   assign test_idx    = r_test_idx;
   assign state_chg   = r_state_chg;

endmodule

// File: tb/tb_pet_need_fsm.sv
// Directed bench for pet_need_fsm; SLEEP checks run when PET_NEED_SLEEP_EN is defined.
module tb_pet_need_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       btn_feed;
   logic       test_mode;
   logic       test_step_raw;
   logic       light_dark;
   logic [2:0] state;
   logic [1:0] food_level;
   logic       feed_enable;
   logic [1:0] test_idx;
   logic       state_chg;

   int n_tests = 0;
   int n_fail  = 0;
   int chg_cnt;

   pet_need_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .tick          (tick),
      .btn_feed      (btn_feed),
      .test_mode     (test_mode),
      .test_step_raw (test_step_raw),
      .light_dark    (light_dark),
      .state         (state),
      .food_level    (food_level),
      .feed_enable   (feed_enable),
      .test_idx      (test_idx),
      .state_chg     (state_chg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   endtask

   // Raw step held 4 clk high then 4 clk low, counting state_chg pulses.
   task automatic raw_step();
      test_step_raw = 1'b1;
      repeat (4) begin @(negedge clk); chg_cnt += int'(state_chg); end
      test_step_raw = 1'b0;
      repeat (4) begin @(negedge clk); chg_cnt += int'(state_chg); end
   endtask

   initial begin
      reset = 1'b0; tick = 1'b0; btn_feed = 1'b0; test_mode = 1'b0;
      test_step_raw = 1'b0; light_dark = 1'b0; chg_cnt = 0;
      clk_n(3);
      check("rst_state", 32'(state), 0);
      check("rst_level", 32'(food_level), 3);
      check("rst_feed_en", 32'(feed_enable), 1);
      check("rst_idx", 32'(test_idx), 0);
      check("rst_chg", 32'(state_chg), 0);
      reset = 1'b1;
      clk_n(1);
      $display("[TB] reset released");

      // Decay 3 -> 2 on the 4th tick, HUNGRY one clk later
      do_ticks(3);
      check("decay_pre", 32'(food_level), 3);
      do_ticks(1);
      check("decay_lvl2", 32'(food_level), 2);
      check("decay_still_idle", 32'(state), 0);
      clk_n(1);
      check("hungry", 32'(state), 1);
      check("hungry_chg", 32'(state_chg), 1);
      clk_n(1);
      check("chg_one_cycle", 32'(state_chg), 0);
      $display("[TB] decay to HUNGRY done");

      do_ticks(8);
      check("decay_lvl0", 32'(food_level), 0);
      clk_n(1);
      check("starving", 32'(state), 2);
      do_ticks(4);
      check("lvl_sat0", 32'(food_level), 0);
      $display("[TB] decay to STARVING done");

      // Feed from STARVING to full
      btn_feed = 1'b1;
      clk_n(1);
      check("eating", 32'(state), 3);
      check("eat_feed_en", 32'(feed_enable), 0);
      do_ticks(3);
      check("fed_lvl3", 32'(food_level), 3);
      check("fed_still_eating", 32'(state), 3);
      clk_n(1);
      check("full_idle", 32'(state), 0);
      check("idle_feed_en", 32'(feed_enable), 1);
      btn_feed = 1'b0;
      $display("[TB] feed to full done");

      // Release feed at level 1 -> HUNGRY
      do_ticks(4);
      clk_n(1);
      check("hungry_again", 32'(state), 1);
      do_ticks(4);
      check("lvl1", 32'(food_level), 1);
      btn_feed = 1'b1;
      clk_n(1);
      check("eat_lvl1", 32'(state), 3);
      btn_feed = 1'b0;
      clk_n(1);
      check("release_hungry", 32'(state), 1);
      $display("[TB] feed release done");

      // Test stepping with tick held high: level must not move
      test_mode = 1'b1;
      tick = 1'b1;
      clk_n(2);
      check("tm_entry_state", 32'(state), 0);
      check("tm_feed_en", 32'(feed_enable), 0);
      chg_cnt = 0;
      for (int i = 1; i <= 4; i++) begin
         raw_step();
         check("tm_idx", 32'(test_idx), 32'(i % 4));
         check("tm_state", 32'(state), 32'(i % 4));
         $display("[TB] test step %0d idx=%0d state=%0d", i, test_idx, state);
      end
      check("tm_chg_count", 32'(chg_cnt), 4);
      check("tm_lvl_frozen", 32'(food_level), 1);

      // Long step pulse yields one increment
      test_step_raw = 1'b1;
      clk_n(50);
      test_step_raw = 1'b0;
      clk_n(5);
      check("long_step", 32'(test_idx), 1);
      raw_step();
      raw_step();
      check("tm_idx3", 32'(test_idx), 3);
      check("tm_state3", 32'(state), 3);
      $display("[TB] long step done");

      // Exit test mode from EATING at level 1 -> HUNGRY
      tick = 1'b0;
      test_mode = 1'b0;
      clk_n(1);
      check("exit_idx", 32'(test_idx), 0);
      check("exit_state", 32'(state), 1);
      check("exit_feed_en", 32'(feed_enable), 1);
      check("exit_lvl", 32'(food_level), 1);
      raw_step();
      raw_step();
      check("no_tm_idx", 32'(test_idx), 0);
      check("no_tm_state", 32'(state), 1);
      $display("[TB] test exit done");

      // Reset mid-EATING at level 2
      btn_feed = 1'b1;
      clk_n(1);
      do_ticks(1);
      check("mid_eat_lvl", 32'(food_level), 2);
      check("mid_eat_state", 32'(state), 3);
      #2 reset = 1'b0;
      #1;
      check("arst_state", 32'(state), 0);
      check("arst_level", 32'(food_level), 3);
      check("arst_feed_en", 32'(feed_enable), 1);
      check("arst_idx", 32'(test_idx), 0);
      check("arst_chg", 32'(state_chg), 0);
      btn_feed = 1'b0;
      clk_n(2);
      reset = 1'b1;
      clk_n(1);
      check("post_rst_state", 32'(state), 0);
      $display("[TB] async reset done");

`ifdef PET_NEED_SLEEP_EN
      light_dark = 1'b1;
      do_ticks(2);
      check("sleep_enter", 32'(state), 4);
      do_ticks(10);
      check("sleep_lvl", 32'(food_level), 3);
      check("sleep_feed_en", 32'(feed_enable), 0);
      light_dark = 1'b0;
      do_ticks(1);
      check("sleep_exit", 32'(state), 0);
      $display("[TB] sleep done");
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
